// File: rtl/pattern_scan_counter_if.sv
// Control, memory-load and result bundle for pattern_scan_counter.
// The master drives start/pattern/load; the slave returns status and display.
interface pattern_scan_counter_if #(
  parameter int WORD_W     = 8,
  parameter int DEPTH      = 9,
  parameter int PAT_W      = 4,
  parameter int CNT_DIGITS = 2
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                      start;
  logic                      mode;
  logic [PAT_W-1:0]          pattern;
  logic                      we;
  logic [AW-1:0]             waddr;
  logic [WORD_W-1:0]         wdata;
  logic                      busy;
  logic                      done;
  logic [4*CNT_DIGITS-1:0]   count_bcd;
  logic [7*CNT_DIGITS-1:0]   seg;

  modport master (
    output start, mode, pattern, we, waddr, wdata,
    input  busy, done, count_bcd, seg
  );

  modport slave (
    input  start, mode, pattern, we, waddr, wdata,
    output busy, done, count_bcd, seg
  );
endinterface

// File: rtl/pattern_scan_counter.sv
// Scans a small word memory for a bit pattern, one window per clock,
// and counts hits as a saturating BCD value with 7-segment outputs.
module pattern_scan_counter #(
  parameter int WORD_W     = 8,
  parameter int DEPTH      = 9,
  parameter int PAT_W      = 4,
  parameter int CNT_DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  pattern_scan_counter_if.slave bus
);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAXOFF = WORD_W - PAT_W;
  localparam int OW     = (MAXOFF > 0) ? $clog2(MAXOFF + 1) : 1;
  localparam int CW     = 4 * CNT_DIGITS;

  localparam logic [31:0] MAXOFF_U = 32'(MAXOFF);
  localparam logic [31:0] LASTA_U  = 32'(DEPTH - 1);
  localparam logic [31:0] DEPTH_U  = 32'(DEPTH);
  localparam logic [WORD_W-1:0] MASK =
    {WORD_W{1'b1}} >> (WORD_W - PAT_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_FIN
  } state_e;

  state_e            state_q, state_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              mode_q, mode_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [OW-1:0]     off_q, off_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] mem_q [DEPTH];

  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] win;
  logic [31:0]       sh;
  logic              diag_ok;
  logic              last_off;
  logic              last;
  logic              hit;

  function automatic logic [CW-1:0] bcd_inc(
    input logic [CW-1:0] v
  );
    logic [CW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < CNT_DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    // a carry out of the top digit means all-9s: hold
    return c ? v : r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    rd_word  = mem_q[addr_q];
    sh       = mode_q ? 32'(addr_q) : 32'(off_q);
    win      = rd_word >> sh;
    diag_ok  = 32'(addr_q) <= MAXOFF_U;
    last_off = 32'(off_q) == MAXOFF_U;
    last     = (32'(addr_q) == LASTA_U) && (mode_q || last_off);
    hit      = (((win ^ WORD_W'(pat_q)) & MASK) == '0)
               && (!mode_q || diag_ok);
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SCAN;
          pat_d   = bus.pattern;
          mode_d  = bus.mode;
          cnt_d   = '0;
          addr_d  = '0;
          off_d   = '0;
        end
      end
      S_SCAN: begin
        if (hit) cnt_d = bcd_inc(cnt_q);
        if (last) begin
          state_d = S_FIN;
        end else if (mode_q || last_off) begin
          addr_d = addr_q + 1'b1;
          off_d  = '0;
        end else begin
          off_d = off_q + 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
    end
  end

  // image is frozen outside IDLE so a scan sees consistent data
  always_ff @(posedge clk) begin
    if (bus.we && state_q == S_IDLE
        && 32'(bus.waddr) < DEPTH_U) begin
      mem_q[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    bus.busy      = state_q == S_SCAN;
    bus.done      = state_q == S_FIN;
    bus.count_bcd = cnt_q;
    for (int i = 0; i < CNT_DIGITS; i++) begin
      bus.seg[7*i +: 7] = seg7(cnt_q[4*i +: 4]);
    end
  end
endmodule
